// File: rtl/layer_pkg.sv
// Shared definitions for the layer RAM path.
// - layer_state_t : FSM states of the WS281x transmitter (layer_tx)
// - GRB_*         : bit positions of the G/R/B fields inside a RAM word
// - CMD_*         : SPI command codes used by layer_ctrl
// - ticks_min1    : maps a timing value of 0 to 1 tick
package layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_GAP,
        ST_DONE
    } layer_state_t;

    // RAM word layout: [23:0] = {G, R, B}, [31:24] unused
    localparam int GRB_W     = 24;
    localparam int GRB_G_MSB = 23;
    localparam int GRB_G_LSB = 16;
    localparam int GRB_R_MSB = 15;
    localparam int GRB_R_LSB = 8;
    localparam int GRB_B_MSB = 7;
    localparam int GRB_B_LSB = 0;

    // Command codes of the SPI decoder
    localparam logic [7:0] CMD_CONF = 8'h2a;
    localparam logic [7:0] CMD_ADDR = 8'h2b;
    localparam logic [7:0] CMD_DATA = 8'h2c;

    // A zero-length phase would never end cleanly; treat it as one tick.
    function automatic logic [7:0] ticks_min1(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/layer_tx_tick_div.sv
// Timing-tick prescaler.
// - clk_i   : system clock
// - rst_n_i : asynchronous active-low reset
// - clr_i   : restart the count at 0 on the next clock (phase boundary)
// - tick_o  : high during the last clk of every TICK_DIV-clk period
module tick_div #(
    parameter int TICK_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr_i || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // With TICK_DIV=1 the counter sits at 0 and every clk is a tick.
    assign tick_o = (cnt == CNT_LAST);

endmodule

// File: rtl/layer_tx.sv
// WS281x transmitter: reads LED_NUM GRB words from the layer RAM and
// drives the serial line, bit by bit, MSB first, then a latch gap.
// - clk_i, rst_n_i        : clock, asynchronous active-low reset
// - start_i               : frame start pulse, accepted only in IDLE
// - t0h_i/t0l_i/t1h_i/t1l_i : pulse timings in ticks, latched at start
// - rd_en_o, rd_addr_o    : RAM read strobe / word address
// - rd_data_i             : RAM word, valid 1 clk after rd_en_o
// - bit_code_o            : registered serial line
// - busy_o, done_o        : frame in progress / end-of-frame pulse
// - state_o               : current FSM state (debug)
//
// Handshake: start_i is a single-cycle request with no ready; it is only
// honoured while busy_o is low, pulses during a frame are dropped.
module layer_tx
    import layer_pkg::*;
#(
    parameter int LED_NUM   = 64,
    parameter int TICK_DIV  = 10,
    parameter int RST_TICKS = 1600
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [7:0]   t0h_i,
    input  logic [7:0]   t0l_i,
    input  logic [7:0]   t1h_i,
    input  logic [7:0]   t1l_i,
    output logic         rd_en_o,
    output logic [5:0]   rd_addr_o,
    input  logic [31:0]  rd_data_i,
    output logic         bit_code_o,
    output logic         busy_o,
    output logic         done_o,
    output layer_state_t state_o
);

    localparam int GW = $clog2(RST_TICKS + 1);
    localparam logic [5:0]    LAST_ADDR = 6'(LED_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(RST_TICKS - 1);

    layer_state_t state, state_next;

    logic [7:0]    t0h_r, t0l_r, t1h_r, t1l_r;
    logic [5:0]    addr;
    logic [23:0]   sreg;
    logic [4:0]    bit_cnt;
    logic [7:0]    ph_cnt;
    logic [GW-1:0] gap_cnt;

    logic       tick;
    logic       state_chg;
    logic [7:0] phase_len;
    logic       phase_end;
    logic       gap_end;

    // Top byte of the RAM word carries no pixel data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data_i[31:24];

    // Every state entry restarts the prescaler so phases are whole ticks.
    assign state_chg = (state_next != state);

    tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .clr_i  (state_chg),
        .tick_o (tick)
    );

    // Length of the current HIGH or LOW phase, chosen by the bit on the wire.
    always_comb begin
        phase_len = 8'd1;
        if (state == ST_HIGH) begin
            phase_len = ticks_min1(sreg[23] ? t1h_r : t0h_r);
        end else begin
            phase_len = ticks_min1(sreg[23] ? t1l_r : t0l_r);
        end
    end

    assign phase_end = tick && (ph_cnt == (phase_len - 8'd1));
    assign gap_end   = tick && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_i) state_next = ST_READ;
            ST_READ: state_next = ST_WAIT;
            ST_WAIT: state_next = ST_LOAD;
            ST_LOAD: state_next = ST_HIGH;
            ST_HIGH: if (phase_end) state_next = ST_LOW;
            ST_LOW: begin
                if (phase_end) begin
                    if (bit_cnt != 5'd0) begin
                        state_next = ST_HIGH;
                    end else if (addr != LAST_ADDR) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP:  if (gap_end) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign state_o = state;

    // Datapath: timing latch, address, shift register and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t0h_r   <= '0;
            t0l_r   <= '0;
            t1h_r   <= '0;
            t1l_r   <= '0;
            addr    <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
            ph_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if ((state == ST_IDLE) && start_i) begin
                t0h_r <= t0h_i;
                t0l_r <= t0l_i;
                t1h_r <= t1h_i;
                t1l_r <= t1l_i;
                addr  <= '0;
            end

            if (state == ST_LOAD) begin
                sreg    <= rd_data_i[GRB_G_MSB:GRB_B_LSB];
                bit_cnt <= 5'd23;
            end

            if ((state == ST_LOW) && phase_end) begin
                if (bit_cnt != 5'd0) begin
                    sreg    <= {sreg[22:0], 1'b0};
                    bit_cnt <= bit_cnt - 5'd1;
                end else if (addr != LAST_ADDR) begin
                    addr <= addr + 6'd1;
                end
            end

            if (state_chg) begin
                ph_cnt <= '0;
            end else if (tick && ((state == ST_HIGH) || (state == ST_LOW))) begin
                ph_cnt <= ph_cnt + 8'd1;
            end

            if (state_chg) begin
                gap_cnt <= '0;
            end else if (tick && (state == ST_GAP)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state register and cannot glitch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_code_o <= 1'b0;
            rd_en_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            bit_code_o <= (state_next == ST_HIGH);
            rd_en_o    <= (state_next == ST_READ);
            busy_o     <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_o     <= (state_next == ST_DONE);
        end
    end

    // addr is itself a register and already holds the word being fetched.
    assign rd_addr_o = addr;

endmodule

// File: tb/tb_layer_tx.sv
module tb_layer_tx;
    import layer_pkg::*;

    localparam int RST_A = 5;
    localparam int RST_B = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] t0h, t0l, t1h, t1l;

    logic         rd_en_a, bit_a, busy_a, done_a;
    logic [5:0]   addr_a;
    logic [31:0]  rdata_a = '0;
    layer_state_t st_a;

    logic         rd_en_b, bit_b, busy_b, done_b;
    logic [5:0]   addr_b;
    logic [31:0]  rdata_b = '0;
    layer_state_t st_b;

    logic [31:0] mem_a [2];
    logic [31:0] mem_b [2];

    always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a[0]];
    always @(posedge clk) if (rd_en_b) rdata_b <= mem_b[addr_b[0]];

    layer_tx #(.LED_NUM(2), .TICK_DIV(1), .RST_TICKS(RST_A)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a),
        .t0h_i(t0h), .t0l_i(t0l), .t1h_i(t1h), .t1l_i(t1l),
        .rd_en_o(rd_en_a), .rd_addr_o(addr_a), .rd_data_i(rdata_a),
        .bit_code_o(bit_a), .busy_o(busy_a), .done_o(done_a), .state_o(st_a)
    );

    layer_tx #(.LED_NUM(2), .TICK_DIV(4), .RST_TICKS(RST_B)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b),
        .t0h_i(t0h), .t0l_i(t0l), .t1h_i(t1h), .t1l_i(t1l),
        .rd_en_o(rd_en_b), .rd_addr_o(addr_b), .rd_data_i(rdata_b),
        .bit_code_o(bit_b), .busy_o(busy_b), .done_o(done_b), .state_o(st_b)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];   // expected line run lengths, starting with low
    int          runs_q[$];  // observed run lengths up to done_o
    logic        line_s[$], busy_s[$], done_s[$], rden_s[$];
    logic [5:0]  addr_s[$];
    int          done_idx, done_cnt;

    // Expected run lengths of a 2-LED frame: 3 clk fetch, then per bit a
    // high run and a low run; the last bit of LED0 absorbs the second
    // fetch, the last bit of LED1 absorbs the latch gap.
    task automatic build_exp(input logic [23:0] w0, input logic [23:0] w1,
                             input int th0, input int tl0, input int th1,
                             input int tl1, input int td, input int rst);
        logic [23:0] w;
        int h, l;
        exp_q.delete();
        exp_q.push_back(16'd3);
        for (int led = 0; led < 2; led++) begin
            w = (led == 0) ? w0 : w1;
            for (int b = 23; b >= 0; b--) begin
                h = w[b] ? th1 : th0;
                l = w[b] ? tl1 : tl0;
                if (h == 0) h = 1;
                if (l == 0) l = 1;
                exp_q.push_back(16'(h * td));
                l = l * td;
                if (b == 0 && led == 0) l = l + 3;
                if (b == 0 && led == 1) l = l + rst * td;
                exp_q.push_back(16'(l));
            end
        end
    endtask

    // ---------------- driver / capture ----------------
    // Pulses start on one DUT, samples its outputs on every negedge from
    // the first cycle after the accepting edge, stops `extra` cycles past
    // the first done_o, then splits the line into run lengths.
    task automatic run_frame(input int which, input int extra);
        int  after;
        bit  seen;
        int  run;
        logic lvl;
        line_s.delete(); busy_s.delete(); done_s.delete();
        rden_s.delete(); addr_s.delete(); runs_q.delete();
        after = 0;
        seen  = 0;
        @(negedge clk);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            line_s.push_back(which == 0 ? bit_a   : bit_b);
            busy_s.push_back(which == 0 ? busy_a  : busy_b);
            done_s.push_back(which == 0 ? done_a  : done_b);
            rden_s.push_back(which == 0 ? rd_en_a : rd_en_b);
            addr_s.push_back(which == 0 ? addr_a  : addr_b);
            if (seen) after++;
            else if (done_s[$] === 1'b1) seen = 1;
            if (seen && after >= extra) break;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL capture_timeout: done_o not seen within 3000 clk (dut %0d)", which);
        end
        done_idx = -1;
        done_cnt = 0;
        foreach (done_s[i]) begin
            if (done_s[i] === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
        end
        run = 0;
        lvl = line_s[0];
        for (int i = 0; i < ((done_idx < 0) ? line_s.size() : done_idx); i++) begin
            if (line_s[i] === lvl) begin
                run++;
            end else begin
                runs_q.push_back(run);
                run = 1;
                lvl = line_s[i];
            end
        end
        runs_q.push_back(run);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        t0h = 8'd1; t0l = 8'd2; t1h = 8'd3; t1l = 8'd1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bit_a, busy_a, done_a, rd_en_a, addr_a} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_out_a: got %b required 0", {bit_a, busy_a, done_a, rd_en_a, addr_a});
        end
        n_tests++;
        if ({bit_b, busy_b, done_b, rd_en_b, addr_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_out_b: got %b required 0", {bit_b, busy_b, done_b, rd_en_b, addr_b});
        end
        n_tests++;
        if (st_a !== ST_IDLE || st_b !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d/%0d required %0d", st_a, st_b, ST_IDLE);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame;
        int rd_idx[$];
        int bad;
        mem_a[0] = 32'hFFA5_0000;  // top byte must be ignored
        mem_a[1] = 32'h0000_0001;
        t0h = 8'd1; t0l = 8'd2; t1h = 8'd3; t1l = 8'd1;
        build_exp(24'hA50000, 24'h000001, 1, 2, 3, 1, 1, RST_A);
        run_frame(0, 10);
        n_tests++;
        if (runs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL frame_runs: got %0d runs required %0d", runs_q.size(), exp_q.size());
        end
        for (int i = 0; i < runs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (runs_q[i] !== int'(exp_q[i])) begin
                n_fail++;
                $display("FAIL frame_run[%0d]: got %0d clk required %0d", i, runs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (line_s[3] !== 1'b1 || line_s[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL first_high: line[2..3]=%b%b required 01", line_s[2], line_s[3]);
        end
        n_tests++;
        if (done_idx !== 160) begin
            n_fail++;
            $display("FAIL frame_done_idx: got %0d required 160", done_idx);
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL frame_done_cnt: got %0d required 1", done_cnt);
        end
        foreach (rden_s[i]) if (rden_s[i] === 1'b1) rd_idx.push_back(i);
        n_tests++;
        if (rd_idx.size() !== 2 || rd_idx[0] !== 0 || rd_idx[1] !== 79) begin
            n_fail++;
            $display("FAIL rd_en_slots: got %0d strobes required 2 at clk 0 and 79", rd_idx.size());
        end
        n_tests++;
        if (rd_idx.size() == 2 && (addr_s[rd_idx[0]] !== 6'd0 || addr_s[rd_idx[1]] !== 6'd1)) begin
            n_fail++;
            $display("FAIL rd_addr: got %0d,%0d required 0,1", addr_s[rd_idx[0]], addr_s[rd_idx[1]]);
        end
        bad = 0;
        for (int i = 0; i < done_idx; i++) if (busy_s[i] !== 1'b1) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_high: %0d cycles low before done, required 0", bad);
        end
        bad = 0;
        for (int i = done_idx; i >= 0 && i < busy_s.size(); i++)
            if (busy_s[i] !== 1'b0 || line_s[i] !== 1'b0) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_drop: %0d cycles busy/line high from done on, required 0", bad);
        end
    endtask

    task automatic test_zero_div4;
        mem_b[0] = 32'h0080_0000;
        mem_b[1] = 32'h0000_0000;
        t0h = 8'd0; t0l = 8'd1; t1h = 8'd3; t1l = 8'd1;
        build_exp(24'h800000, 24'h000000, 0, 1, 3, 1, 4, RST_B);
        run_frame(1, 4);
        n_tests++;
        if (runs_q.size() < 4 || runs_q[1] !== 12 || runs_q[2] !== 4 || runs_q[3] !== 4) begin
            n_fail++;
            $display("FAIL div4_first: got %0d/%0d/%0d required 12/4/4",
                     runs_q.size() > 1 ? runs_q[1] : -1, runs_q.size() > 2 ? runs_q[2] : -1,
                     runs_q.size() > 3 ? runs_q[3] : -1);
        end
        n_tests++;
        if (runs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL div4_runs: got %0d runs required %0d", runs_q.size(), exp_q.size());
        end
        for (int i = 0; i < runs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (runs_q[i] !== int'(exp_q[i])) begin
                n_fail++;
                $display("FAIL div4_run[%0d]: got %0d clk required %0d", i, runs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (done_idx !== 410) begin
            n_fail++;
            $display("FAIL div4_done_idx: got %0d required 410", done_idx);
        end
    endtask

    task automatic test_start_ignored;
        t0h = 8'd1; t0l = 8'd2; t1h = 8'd3; t1l = 8'd1;
        build_exp(24'hA50000, 24'h000001, 1, 2, 3, 1, 1, RST_A);
        fork
            run_frame(0, 20);
            begin
                repeat (30) @(negedge clk);
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
        join
        n_tests++;
        if (done_cnt !== 1 || done_idx !== 160) begin
            n_fail++;
            $display("FAIL restart_ignored: done count %0d at %0d, required 1 at 160", done_cnt, done_idx);
        end
        n_tests++;
        if (runs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL restart_runs: got %0d runs required %0d", runs_q.size(), exp_q.size());
        end
        for (int i = 0; i < runs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (runs_q[i] !== int'(exp_q[i])) begin
                n_fail++;
                $display("FAIL restart_run[%0d]: got %0d clk required %0d", i, runs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timing_change;
        t0h = 8'd1; t0l = 8'd2; t1h = 8'd3; t1l = 8'd1;
        build_exp(24'hA50000, 24'h000001, 1, 2, 3, 1, 1, RST_A);
        fork
            run_frame(0, 4);
            begin
                repeat (20) @(negedge clk);
                t1h = 8'd5;
            end
        join
        n_tests++;
        if (done_idx !== 160) begin
            n_fail++;
            $display("FAIL tchg_cur_done: got %0d required 160", done_idx);
        end
        for (int i = 0; i < runs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (runs_q[i] !== int'(exp_q[i])) begin
                n_fail++;
                $display("FAIL tchg_cur_run[%0d]: got %0d clk required %0d", i, runs_q[i], exp_q[i]);
            end
        end
        build_exp(24'hA50000, 24'h000001, 1, 2, 5, 1, 1, RST_A);
        run_frame(0, 4);
        n_tests++;
        if (done_idx !== 170 || runs_q.size() < 2 || runs_q[1] !== 5) begin
            n_fail++;
            $display("FAIL tchg_next: done at %0d first high %0d, required 170 and 5",
                     done_idx, runs_q.size() > 1 ? runs_q[1] : -1);
        end
        for (int i = 0; i < runs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (runs_q[i] !== int'(exp_q[i])) begin
                n_fail++;
                $display("FAIL tchg_next_run[%0d]: got %0d clk required %0d", i, runs_q[i], exp_q[i]);
            end
        end
        t1h = 8'd3;
    endtask

    task automatic test_reset_mid;
        bit hit;
        hit = 0;
        t0h = 8'd1; t0l = 8'd2; t1h = 8'd3; t1l = 8'd1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (bit_a === 1'b1) hit = 1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_wait: line high not seen within 20 clk");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bit_a !== 1'b0 || busy_a !== 1'b0 || rd_en_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: bit/busy/rd_en/done=%b%b%b%b required 0000",
                     bit_a, busy_a, rd_en_a, done_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_exp(24'hA50000, 24'h000001, 1, 2, 3, 1, 1, RST_A);
        run_frame(0, 4);
        n_tests++;
        if (done_idx !== 160 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL rstmid_frame_done: got %0d pulses at %0d required 1 at 160", done_cnt, done_idx);
        end
        for (int i = 0; i < runs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (runs_q[i] !== int'(exp_q[i])) begin
                n_fail++;
                $display("FAIL rstmid_run[%0d]: got %0d clk required %0d", i, runs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_frame();
        test_zero_div4();
        test_start_ignored();
        test_timing_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
